// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: owns the single-port framebuffer RAM of the light-pen screen.
// Shares the RAM between the row-scan read path and the pen write path, runs
// the framebuffer clear on entry into the RST mode, and holds the pen colour.
//
//   ctrl state | meaning
//   -----------+-----------------------------------------------------------
//   IDLE       | normal operation, scan/pen arbitration active
//   CLEAR      | writing 0 to every pixel, one address per cycle
//   DONE       | clear finished, rst_ok high until mode leaves RST
module fb_port_arbiter #(
  parameter int AW         = 6,
  parameter int DW         = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [2:0]    state,
  input  logic          scan_req,
  input  logic [AW-1:0] scan_addr,
  output logic          scan_ack,
  output logic          scan_valid,
  output logic [DW-1:0] scan_data,
  input  logic          pen_req,
  input  logic [AW-1:0] pen_addr,
  output logic          pen_ack,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          rst_ok,
  output logic [DW-1:0] cur_color
);

  localparam logic [2:0] MODE_RST   = 3'd0;
  localparam logic [2:0] MODE_DRAW  = 3'd3;
  localparam logic [2:0] MODE_WRITE = 3'd4;
  localparam logic [2:0] MODE_ERASE = 3'd5;
  localparam logic [2:0] MODE_COLOR = 3'd6;

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [AW-1:0] CLR_LAST   = '1;
  localparam logic [DW-1:0] COLOR_MAX  = '1;
  localparam logic [DW-1:0] COLOR_ONE  = DW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } ctrl_t;

  ctrl_t          ctrl_q, ctrl_d;
  logic [AW-1:0]  clr_cnt_q, clr_cnt_d;
  logic [SW-1:0]  starve_q, starve_d;
  logic [DW-1:0]  color_q, color_d;
  logic           prev_rst_q;
  logic           rst_ok_q;
  logic           scan_valid_q;

  logic           in_rst;
  logic           rst_entry;
  logic           arb_en;
  logic           forced;
  logic           color_step;

  assign in_rst    = (state == MODE_RST);
  // Entry is an edge on the mode; prev_rst_q resets low so RST right after reset counts.
  assign rst_entry = in_rst && !prev_rst_q;
  // Arbitration runs only in IDLE outside RST, and is held off while rst_n is low
  // so the RAM strobes and acks read 0 during reset regardless of the requests.
  assign arb_en    = rst_n && (ctrl_q == IDLE) && !in_rst;
  // Forcing only matters if the pen is still asking; otherwise scan may proceed.
  assign forced    = (starve_q == STARVE_LIM) && pen_req;

  // Control FSM state, clear counter and the remembered previous mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q     <= IDLE;
      clr_cnt_q  <= '0;
      prev_rst_q <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      clr_cnt_q  <= clr_cnt_d;
      prev_rst_q <= in_rst;
    end
  end

  // Next-state logic; a fresh RST entry restarts the clear from any state.
  always_comb begin
    ctrl_d    = ctrl_q;
    clr_cnt_d = clr_cnt_q;
    if (rst_entry) begin
      ctrl_d    = CLEAR;
      clr_cnt_d = '0;
    end else begin
      case (ctrl_q)
        IDLE: begin
          ctrl_d = IDLE;
        end
        CLEAR: begin
          clr_cnt_d = clr_cnt_q + AW'(1);
          if (clr_cnt_q == CLR_LAST) begin
            ctrl_d = DONE;
          end
        end
        DONE: begin
          if (!in_rst) begin
            ctrl_d = IDLE;
          end
        end
        default: begin
          ctrl_d    = IDLE;
          clr_cnt_d = '0;
        end
      endcase
    end
  end

  // RAM port mux and request grants: clear writes, else scan, else pen.
  always_comb begin
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;
    scan_ack   = 1'b0;
    pen_ack    = 1'b0;
    color_step = 1'b0;
    if (rst_n && (ctrl_q == CLEAR)) begin
      ram_en   = 1'b1;
      ram_we   = 1'b1;
      ram_addr = clr_cnt_q;
    end else if (arb_en) begin
      if (scan_req && !forced) begin
        scan_ack = 1'b1;
        ram_en   = 1'b1;
        ram_addr = scan_addr;
      end else if (pen_req) begin
        pen_ack = 1'b1;
        case (state)
          MODE_DRAW, MODE_WRITE: begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = pen_addr;
            ram_wdata = color_q;
          end
          MODE_ERASE: begin
            ram_en   = 1'b1;
            ram_we   = 1'b1;
            ram_addr = pen_addr;
          end
          MODE_COLOR: begin
            color_step = 1'b1;
          end
          default: begin
            color_step = 1'b0;
          end
        endcase
      end
    end
  end

  // Starve count saturates while the pen waits; colour skips 0 when wrapping.
  always_comb begin
    starve_d = '0;
    if (pen_req && !pen_ack) begin
      starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + SW'(1);
    end
    color_d = color_q;
    if (color_step) begin
      color_d = (color_q == COLOR_MAX) ? COLOR_ONE : color_q + COLOR_ONE;
    end
  end

  // Arbitration history, pen colour and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q     <= '0;
      color_q      <= COLOR_ONE;
      rst_ok_q     <= 1'b0;
      scan_valid_q <= 1'b0;
    end else begin
      starve_q     <= starve_d;
      color_q      <= color_d;
      rst_ok_q     <= (ctrl_d == DONE);
      scan_valid_q <= scan_ack;
    end
  end

  assign rst_ok     = rst_ok_q;
  assign scan_valid = scan_valid_q;
  assign scan_data  = scan_valid_q ? ram_rdata : '0;
  assign cur_color  = color_q;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter with a behavioural 64x2 RAM attached.
module tb_fb_port_arbiter;

  localparam int AW = 6;
  localparam int DW = 2;
  localparam logic [2:0] M_RST   = 3'd0;
  localparam logic [2:0] M_SLEEP = 3'd1;
  localparam logic [2:0] M_DRAW  = 3'd3;
  localparam logic [2:0] M_ERASE = 3'd5;
  localparam logic [2:0] M_COLOR = 3'd6;

  logic          clk;
  logic          rst_n;
  logic [2:0]    state;
  logic          scan_req;
  logic [AW-1:0] scan_addr;
  logic          scan_ack;
  logic          scan_valid;
  logic [DW-1:0] scan_data;
  logic          pen_req;
  logic [AW-1:0] pen_addr;
  logic          pen_ack;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          rst_ok;
  logic [DW-1:0] cur_color;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  int            wr_cnt;
  int            n_cmp;
  int            n_err;

  fb_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n), .state(state),
    .scan_req(scan_req), .scan_addr(scan_addr), .scan_ack(scan_ack),
    .scan_valid(scan_valid), .scan_data(scan_data),
    .pen_req(pen_req), .pen_addr(pen_addr), .pen_ack(pen_ack),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .rst_ok(rst_ok), .cur_color(cur_color)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM with one-cycle read latency; starts filled with 3.
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 2'd3;
    ram_rdata = '0;
    wr_cnt    = 0;
  end
  always @(posedge clk) begin
    if (ram_en && ram_we) begin
      mem[ram_addr] <= ram_wdata;
      wr_cnt        <= wr_cnt + 1;
    end else if (ram_en) begin
      ram_rdata <= mem[ram_addr];
    end
  end

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int colors [4];
    int wr_snap;
    colors = '{2, 3, 1, 2};
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0; state = M_RST;
    scan_req = 1'b0; scan_addr = '0; pen_req = 1'b0; pen_addr = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #2;
    check_eq("rst_rst_ok", rst_ok, 0);
    check_eq("rst_cur_color", cur_color, 1);
    check_eq("rst_ram_en", ram_en, 0);
    check_eq("rst_scan_valid", scan_valid, 0);
    check_eq("rst_scan_data", scan_data, 0);

    // Release with RST held: 64 clear writes then rst_ok
    rst_n = 1'b1;
    #1 check_eq("entry_ram_en", ram_en, 0);
    cyc();
    for (int i = 0; i < 64; i++) begin
      #1;
      check_eq("clr_we", {ram_en, ram_we}, 3);
      check_eq("clr_addr", ram_addr, i);
      check_eq("clr_wdata", ram_wdata, 0);
      check_eq("clr_rst_ok", rst_ok, 0);
      cyc();
    end
    #1;
    check_eq("done_rst_ok", rst_ok, 1);
    check_eq("done_ram_en", ram_en, 0);
    check_eq("mem63_cleared", mem[63], 0);
    cyc();
    check_eq("done_rst_ok_hold", rst_ok, 1);
    state = M_SLEEP;
    cyc();
    #1 check_eq("sleep_rst_ok", rst_ok, 0);

    // DRAW pen write, then scan read back
    state = M_DRAW; pen_req = 1'b1; pen_addr = 6'd5;
    #1;
    check_eq("draw_pen_ack", pen_ack, 1);
    check_eq("draw_we", {ram_en, ram_we}, 3);
    check_eq("draw_addr", ram_addr, 5);
    check_eq("draw_wdata", ram_wdata, 1);
    cyc();
    pen_req = 1'b0; scan_req = 1'b1; scan_addr = 6'd5;
    #1;
    check_eq("rd_scan_ack", scan_ack, 1);
    check_eq("rd_we", {ram_en, ram_we}, 2);
    check_eq("rd_addr", ram_addr, 5);
    cyc();
    scan_req = 1'b0;
    #1;
    check_eq("rd_valid", scan_valid, 1);
    check_eq("rd_data", scan_data, 1);
    cyc();
    check_eq("rd_valid_drop", scan_valid, 0);

    // COLOR handshakes: no RAM traffic, colour 2,3,1,2
    state = M_COLOR;
    wr_snap = wr_cnt;
    for (int k = 0; k < 4; k++) begin
      pen_req = 1'b1;
      #1;
      check_eq("color_pen_ack", pen_ack, 1);
      check_eq("color_ram_en", ram_en, 0);
      cyc();
      pen_req = 1'b0;
      check_eq("color_value", cur_color, colors[k]);
    end
    check_eq("color_no_writes", wr_cnt, wr_snap);

    // ERASE write to addr 5, read back 0
    state = M_ERASE; pen_req = 1'b1; pen_addr = 6'd5;
    #1;
    check_eq("erase_pen_ack", pen_ack, 1);
    check_eq("erase_we", {ram_en, ram_we}, 3);
    check_eq("erase_wdata", ram_wdata, 0);
    cyc();
    pen_req = 1'b0; scan_req = 1'b1; scan_addr = 6'd5;
    cyc();
    scan_req = 1'b0;
    #1 check_eq("erase_rd_data", scan_data, 0);
    cyc();

    // Starvation: pen loses 4 cycles, forced on the 5th
    state = M_DRAW;
    scan_req = 1'b1; scan_addr = 6'd7; pen_req = 1'b1; pen_addr = 6'd9;
    for (int c = 0; c < 4; c++) begin
      #1;
      check_eq("starve_scan_ack", scan_ack, 1);
      check_eq("starve_pen_ack", pen_ack, 0);
      cyc();
    end
    #1;
    check_eq("forced_pen_ack", pen_ack, 1);
    check_eq("forced_scan_ack", scan_ack, 0);
    check_eq("forced_addr", ram_addr, 9);
    check_eq("forced_wdata", ram_wdata, 2);
    cyc();
    pen_req = 1'b0;
    #1;
    check_eq("resume_scan_ack", scan_ack, 1);
    check_eq("resume_no_valid", scan_valid, 0);
    cyc();

    // Re-entry into RST mid-clear restarts at address 0
    state = M_RST; pen_req = 1'b1; scan_req = 1'b1;
    #1;
    check_eq("reent_entry_acks", {scan_ack, pen_ack}, 0);
    cyc();
    for (int i = 0; i < 20; i++) begin
      #1;
      check_eq("reclr_addr", ram_addr, i);
      check_eq("reclr_acks", {scan_ack, pen_ack}, 0);
      cyc();
    end
    state = M_SLEEP;
    #1 check_eq("leave_addr20", ram_addr, 20);
    cyc();
    state = M_RST;
    #1 check_eq("back_addr21", ram_addr, 21);
    cyc();
    for (int i = 0; i < 64; i++) begin
      #1;
      check_eq("fresh_we", {ram_en, ram_we}, 3);
      check_eq("fresh_addr", ram_addr, i);
      check_eq("fresh_rst_ok", rst_ok, 0);
      check_eq("fresh_acks", {scan_ack, pen_ack}, 0);
      cyc();
    end
    #1;
    check_eq("fresh_done_rst_ok", rst_ok, 1);
    check_eq("fresh_done_acks", {scan_ack, pen_ack}, 0);

    // Async reset mid-clear
    pen_req = 1'b0; scan_req = 1'b0;
    state = M_SLEEP;
    cyc();
    state = M_RST;
    repeat (6) cyc();
    #1 check_eq("pre_arst_we", {ram_en, ram_we}, 3);
    scan_req = 1'b1; pen_req = 1'b1;
    rst_n = 1'b0;
    #1;
    check_eq("arst_ram", {ram_en, ram_we}, 0);
    check_eq("arst_acks", {scan_ack, pen_ack}, 0);
    check_eq("arst_rst_ok", rst_ok, 0);
    check_eq("arst_cur_color", cur_color, 1);
    check_eq("arst_scan_valid", scan_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fb_port_arbiter.md
Name: fb_port_arbiter

Overview:
- Owns the single-port display framebuffer RAM of the light-pen screen.
- Shares that RAM between two requesters: the row-scan read path, which refreshes the LED matrix, and the pen write path.
- Runs the framebuffer clear sequence when the mode FSM enters RST, and returns rst_ok to it.
- Holds the current pen colour and applies the active mode (DRAW/WRITE/ERASE/COLOR) to pen writes.

Parameters:
AW, 6, framebuffer address width (64 pixels, 8x8)
DW, 2, pixel colour width; value 0 = pixel off
STARVE_MAX, 4, consecutive cycles a pending pen request may lose to scan before it is forced to win

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
state  in  3  mode from mode FSM: RST=0, SLEEP=1, LIGHT=2, DRAW=3, WRITE=4, ERASE=5, COLOR=6, STOP=7
scan_req  in  1  scan read request
scan_addr  in  AW  scan read address
scan_ack  out  1  scan request granted this cycle
scan_valid  out  1  scan_data valid (one cycle after scan_ack)
scan_data  out  DW  read pixel
pen_req  in  1  pen request; held until pen_ack
pen_addr  in  AW  pen pixel address
pen_ack  out  1  pen request consumed this cycle
ram_en  out  1  RAM access enable
ram_we  out  1  RAM write enable
ram_addr  out  AW  RAM address
ram_wdata  out  DW  RAM write data
ram_rdata  in  DW  RAM read data, 1-cycle latency after ram_en & !ram_we
rst_ok  out  1  clear complete
cur_color  out  DW  current pen colour

Behaviour:
- Reset values (rst_n=0):
  - ctrl FSM = IDLE, clear counter = 0, starve counter = 0.
  - cur_color = 1; rst_ok = 0; scan_valid = 0; scan_data = 0.
  - ram_en, ram_we, scan_ack and pen_ack are all 0.
- ctrl FSM states and transitions:
  - IDLE -> CLEAR when state==RST and the previous-cycle state!=RST (first cycle after reset counts as entry if state==RST).
  - CLEAR: ram_en=ram_we=1, ram_wdata=0, ram_addr=clear counter. Counter increments each cycle. After address 2^AW-1 is written, go to DONE. Duration is exactly 2^AW cycles.
  - DONE: rst_ok=1 (registered, first high the cycle after the last clear write). Remains high while state==RST. When state!=RST, rst_ok drops and the FSM returns to IDLE the same cycle.
  - Re-entry into RST from any state, including mid-CLEAR, restarts CLEAR at address 0 with rst_ok=0.
- During CLEAR and DONE: scan_ack=0 and pen_ack=0. Requests stay pending; no other RAM access occurs.
- IDLE arbitration (combinational grant, single RAM access per cycle):
  - Pen is "forced" when starve counter == STARVE_MAX.
  - scan_req and not forced: scan wins. scan_ack=1, ram_en=1, ram_we=0, ram_addr=scan_addr.
  - Else if pen_req: pen wins. pen_ack=1, and the RAM action depends on state (see pen actions below).
  - Starve counter increments each cycle pen_req=1 and pen_ack=0, saturating at STARVE_MAX. It clears on pen_ack, or when pen_req=0.
- Pen actions on pen_ack, by state:
  - DRAW, WRITE: write cur_color to pen_addr.
  - ERASE: write 0 to pen_addr.
  - COLOR: no RAM access; cur_color increments; DW'max wraps to 1 (0 is never selected).
  - SLEEP, LIGHT, STOP: request dropped; ack issued with no RAM access.
- Forced pen cycle: scan_ack=0 even if scan_req=1. Scan stays pending and wins the next cycle.
- Read return: scan_valid=1 and scan_data=ram_rdata exactly one cycle after scan_ack.
- scan_req and pen_req both 0: ram_en=0.
- cur_color is unaffected by RST/clear; it resets only on rst_n.

Test Plan:
- Reset release with state=RST, hold RST -> ram_we=1 on addresses 0..63 over 64 consecutive cycles, data 0. rst_ok=1 from cycle 65 while RST held. state->SLEEP -> rst_ok=0 next cycle.
- state=DRAW, pen_req addr=5, no scan -> same-cycle pen_ack, RAM write addr 5 data 1. Then scan_req addr=5 -> scan_valid next cycle, scan_data=1.
- state=COLOR, four pen_req handshakes -> cur_color 2,3,1,2 with no RAM writes. Then ERASE pen write to addr 5 -> data 0.
- Continuous scan_req plus pen_req in DRAW -> pen loses 4 cycles, wins the 5th (scan_ack=0 that cycle), scan resumes the following cycle.
- Mid-CLEAR (counter=20), state leaves RST and re-enters RST -> clear restarts at 0. rst_ok stays 0 until 64 fresh writes complete. Pending pen/scan acks stay 0 throughout.
- Assert rst_n low mid-CLEAR -> all outputs reset immediately (async). cur_color=1.
